// File: rtl/board_reader.sv
// Captures a frozen snapshot of the cellular-automaton board and streams it out
// as fixed-width words over valid/ready, accumulating the live-cell population.
module board_reader #(
    parameter int unsigned BOARD_WIDTH  = 32,
    parameter int unsigned BOARD_HEIGHT = 32,
    parameter int unsigned WORD_WIDTH   = 32,
    localparam int unsigned SIZE      = BOARD_WIDTH * BOARD_HEIGHT,
    localparam int unsigned NUM_WORDS = (SIZE + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int unsigned CNT_W     = $clog2(SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE:0]         board_state,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDX_W-1:0]      out_index,
    output logic [CNT_W-1:0]      alive_count
);

    // Word slots are rounded up to a power of two so out_index can never address past the array.
    localparam int unsigned SLOTS = 1 << IDX_W;
    localparam int unsigned PAD_W = SLOTS * WORD_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   snap_q [SLOTS];
    logic [WORD_WIDTH-1:0]   snap_d [SLOTS];
    logic [WORD_WIDTH-1:0]   cap_words [SLOTS];
    logic [PAD_W-1:0]        board_pad;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WORD_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic [CNT_W-1:0]        alive_count_q, alive_count_d;
    logic [CNT_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        word_pop;
    logic [CNT_W-1:0]        acc_sum;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    unused_edge_bit;

    // The off-board edge bit is deliberately dropped; unused padding reads as zero.
    assign unused_edge_bit = board_state[SIZE];
    assign board_pad       = PAD_W'(board_state[SIZE-1:0]);

    always_comb begin
        for (int w = 0; w < int'(SLOTS); w++) begin
            cap_words[w] = board_pad[w*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign word_pop = CNT_W'($countones(out_data_q));
    assign acc_sum  = acc_q + word_pop;
    assign idx_nxt  = out_index_q + IDX_W'(1);

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_index_d   = out_index_q;
        alive_count_d = alive_count_q;
        acc_d         = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SEND;
                    snap_d      = cap_words;
                    acc_d       = '0;
                    out_index_d = '0;
                    out_data_d  = cap_words[0];
                    out_last_d  = (NUM_WORDS == 1);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    acc_d = acc_sum;
                    if (out_last_q) begin
                        state_d       = S_IDLE;
                        alive_count_d = acc_sum;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        out_valid_d   = 1'b0;
                        out_last_d    = 1'b0;
                        out_data_d    = '0;
                        out_index_d   = '0;
                    end else begin
                        out_index_d = idx_nxt;
                        out_data_d  = snap_q[idx_nxt];
                        out_last_d  = (idx_nxt == IDX_W'(NUM_WORDS - 1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            snap_q        <= '{default: '0};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_index_q   <= '0;
            alive_count_q <= '0;
            acc_q         <= '0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_index_q   <= out_index_d;
            alive_count_q <= alive_count_d;
            acc_q         <= acc_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_index   = out_index_q;
    assign alive_count = alive_count_q;

endmodule

// File: doc/board_reader.md
# board_reader

Snapshots the packed cell-state vector of the cellular-automaton board and streams it out as fixed-width words over a valid/ready handshake, so the AXI side can read the current generation. It sits between the cell array and the register/stream interface of the CA core, and also reports the live-cell population of the captured generation.

## Interface
- BOARD_WIDTH, 32, cells per row
- BOARD_HEIGHT, 32, rows
- WORD_WIDTH, 32, bits per output word; NUM_WORDS = ceil(BOARD_WIDTH*BOARD_HEIGHT / WORD_WIDTH)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- board_state  in  BOARD_WIDTH*BOARD_HEIGHT+1  packed cell states, cell (X,Y) at bit Y*BOARD_WIDTH+X; top bit is the off-board edge value and is ignored
- start  in  1  request a capture-and-stream; sampled only in IDLE
- busy  out  1  high from the capture edge through the final word transfer
- done  out  1  one-cycle pulse after the final word transfer
- out_data  out  WORD_WIDTH  current word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_last  out  1  high with the final word (index NUM_WORDS-1)
- out_index  out  clog2(NUM_WORDS) (min 1)  index of the current word
- alive_count  out  clog2(BOARD_WIDTH*BOARD_HEIGHT+1)  live cells in the last completed snapshot

## Operation
- States: IDLE, SEND.
- IDLE: start=1 -> copy board_state[SIZE-1:0] into snapshot, clear the running count, set out_index=0, go to SEND. start=0 -> stay.
- SEND: out_valid=1; out_data = snapshot[out_index*WORD_WIDTH +: WORD_WIDTH]. Bits beyond SIZE-1 in the final word read 0.
- On transfer: add popcount(out_data) to the running count; if out_last, load alive_count with the final sum, go to IDLE, and pulse done next cycle; otherwise increment out_index.
- The snapshot is frozen during SEND: board_state changes after the capture edge never affect the output.
- start in SEND is ignored. It is not queued.
- start can be accepted in the cycle done is high, because the block is already in IDLE.
- alive_count holds its value until the next completed stream. It does not change during a stream.
- Arithmetic: popcount and accumulation are unsigned. The accumulator width equals alive_count width, so it cannot overflow.

## Timing
- Reset (async assert, sync-safe deassert) drives all outputs to 0: busy, done, out_valid, out_last, out_data, out_index, alive_count. State goes to IDLE and the snapshot is cleared.
- Reset mid-stream aborts immediately. alive_count returns to 0, and no done pulse is produced.
- start high at edge t in IDLE: busy and out_valid are high from t+1, and word 0 is on out_data.
- One word per cycle with out_ready held high. The last transfer is at edge t+NUM_WORDS, and done=1 during the cycle after it.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- out_valid never drops before the final transfer.
- busy falls and alive_count updates on the same edge as the final transfer.

## Test plan
- Reset during SEND (32x32, word 5 of 32): assert rst_n=0 -> all outputs 0 asynchronously. After release, start with an empty board -> 32 zero words, alive_count=0.
- Glider at cells (1,0),(2,1),(0,2),(1,2),(2,2), default params, out_ready=1:
  - words 0..2 = 0x00000002, 0x00000004, 0x00000007; words 3..31 = 0.
  - out_last only on index 31; done 33 cycles after start; alive_count=5.
- All cells alive plus edge bit 1024 set:
  - 32 words of 0xFFFFFFFF.
  - alive_count=1024; the edge bit is excluded.
- Random out_ready (~50%) on a random board:
  - data is held stable across every stall and matches the snapshot word for word.
  - the popcount sum equals alive_count.
- Start while busy, then invert board_state one cycle after capture:
  - the second start is ignored.
  - the stream still matches the original board.
  - exactly one done pulse.
- BOARD_WIDTH=5, BOARD_HEIGHT=5, WORD_WIDTH=8, all cells alive:
  - 4 words: 0xFF, 0xFF, 0xFF, 0x01.
  - alive_count=25.
  - a back-to-back start during the done cycle begins a new stream the next cycle.
